wb_register_file: RTL and testbench

ARM general-purpose register file and write-back commit point for the 5-stage pipeline. It consumes the 4-bit WB control word and write-back data registered by the MEM/WB pipeline register. It commits results into R0–R14 and serves three combinational read ports to the ID stage. A write to R15 is converted into a registered PC-redirect pulse for the fetch stage.

---
 rtl/pipeline_pkg.sv | 18 +
 rtl/rf_read_port.sv | 37 +++
 rtl/wb_register_file.sv | 117 +++++++++++
 tb/tb_wb_register_file.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: WB control word layout, the architectural PC
// index, and the default datapath width used by the write-back stage.
package pipeline_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned WB_CTRL_W      = 4;
  localparam int unsigned REG_IDX_W      = 4;

  // Bit positions inside the WB control word; bit 3 is reserved.
  localparam int unsigned WB_RF_WE       = 0;
  localparam int unsigned WB_MEM_TO_REG  = 1;
  localparam int unsigned WB_BYTE_LOAD   = 2;

  localparam logic [REG_IDX_W-1:0] REG_PC = 4'd15;

  typedef logic [WB_CTRL_W-1:0] wb_control_t;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port.
// Ports:
//   addr      - register index to read
//   regs      - stored R0..R14 contents
//   pc_plus8  - value returned for R15
//   byp_en    - a same-cycle write to a stored register is available
//   byp_rd    - index of that write
//   byp_data  - data of that write
//   data      - read result (combinational)
module rf_read_port
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned NSTORE = 15
) (
  input  logic [REG_IDX_W-1:0]          addr,
  input  logic [NSTORE-1:0][DATA_W-1:0] regs,
  input  logic [DATA_W-1:0]             pc_plus8,
  input  logic                          byp_en,
  input  logic [REG_IDX_W-1:0]          byp_rd,
  input  logic [DATA_W-1:0]             byp_data,
  output logic [DATA_W-1:0]             data
);

  // R15 is never stored and never bypassed; byp_en already excludes it.
  always_comb begin
    data = '0;
    if (addr == REG_PC) begin
      data = pc_plus8;
    end else if (byp_en && (addr == byp_rd)) begin
      data = byp_data;
    end else begin
      data = regs[addr];
    end
  end

endmodule

// File: rtl/wb_register_file.sv
// ARM general-purpose register file and write-back commit point.
// Commits WB results into R0..R14, serves three combinational read ports,
// and turns a write to R15 into a registered one-cycle PC-redirect pulse.
// Build option: define RF_BYPASS_EN to forward the write-back value to read
// ports addressing the register being written in the same cycle.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   wb_control, wb_rd             - WB control word and destination index
//   wb_alu_result, wb_mem_data    - write-back data candidates
//   pc_plus8                      - value returned for R15 reads
//   ra/rb/rc_addr, ra/rb/rc_data  - read ports (combinational data)
//   pc_redirect_valid/_target     - registered R15-write redirect
module wb_register_file
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned NREG   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           wb_control,
  input  logic [3:0]           wb_rd,
  input  logic [DATA_W-1:0]    wb_alu_result,
  input  logic [DATA_W-1:0]    wb_mem_data,
  input  logic [DATA_W-1:0]    pc_plus8,
  input  logic [3:0]           ra_addr,
  input  logic [3:0]           rb_addr,
  input  logic [3:0]           rc_addr,
  output logic [DATA_W-1:0]    ra_data,
  output logic [DATA_W-1:0]    rb_data,
  output logic [DATA_W-1:0]    rc_data,
  output logic                 pc_redirect_valid,
  output logic [DATA_W-1:0]    pc_redirect_target
);

  localparam int unsigned NSTORE = NREG - 1;

  wb_control_t                    ctrl;
  logic [NSTORE-1:0][DATA_W-1:0]  regs;
  logic [DATA_W-1:0]              wdata;
  logic                           we_array;
  logic                           we_pc;
  logic                           byp_en;
  logic                           unused_ctrl;

  assign ctrl        = wb_control;
  assign unused_ctrl = ctrl[3];

  // Write-data select: ALU result, full load word, or zero-extended byte.
  always_comb begin
    wdata = wb_alu_result;
    if (ctrl[WB_MEM_TO_REG]) begin
      if (ctrl[WB_BYTE_LOAD]) begin
        wdata = DATA_W'(wb_mem_data[7:0]);
      end else begin
        wdata = wb_mem_data;
      end
    end
  end

  assign we_array = ctrl[WB_RF_WE] && (wb_rd != REG_PC);
  assign we_pc    = ctrl[WB_RF_WE] && (wb_rd == REG_PC);

`ifdef RF_BYPASS_EN
  assign byp_en = we_array;
`else
  assign byp_en = 1'b0;
`endif

  // Storage and redirect register; reset wins over any same-cycle commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs               <= '0;
      pc_redirect_valid  <= 1'b0;
      pc_redirect_target <= '0;
    end else begin
      pc_redirect_valid <= we_pc;
      if (we_pc) begin
        pc_redirect_target <= {wdata[DATA_W-1:2], 2'b00};
      end
      if (we_array) begin
        regs[wb_rd] <= wdata;
      end
    end
  end

  rf_read_port #(.DATA_W(DATA_W), .NSTORE(NSTORE)) u_port_a (
    .addr     (ra_addr),
    .regs     (regs),
    .pc_plus8 (pc_plus8),
    .byp_en   (byp_en),
    .byp_rd   (wb_rd),
    .byp_data (wdata),
    .data     (ra_data)
  );

  rf_read_port #(.DATA_W(DATA_W), .NSTORE(NSTORE)) u_port_b (
    .addr     (rb_addr),
    .regs     (regs),
    .pc_plus8 (pc_plus8),
    .byp_en   (byp_en),
    .byp_rd   (wb_rd),
    .byp_data (wdata),
    .data     (rb_data)
  );

  rf_read_port #(.DATA_W(DATA_W), .NSTORE(NSTORE)) u_port_c (
    .addr     (rc_addr),
    .regs     (regs),
    .pc_plus8 (pc_plus8),
    .byp_en   (byp_en),
    .byp_rd   (wb_rd),
    .byp_data (wdata),
    .data     (rc_data)
  );

endmodule

// File: tb/tb_wb_register_file.sv
// Scoreboard bench for wb_register_file: stimulus pushes expected read and
// redirect values computed from an array-based model; a monitor compares.
module tb_wb_register_file;

  localparam int unsigned W = 32;

  logic          clk;
  logic          reset;
  logic [3:0]    wb_control;
  logic [3:0]    wb_rd;
  logic [W-1:0]  wb_alu_result;
  logic [W-1:0]  wb_mem_data;
  logic [W-1:0]  pc_plus8;
  logic [3:0]    ra_addr, rb_addr, rc_addr;
  logic [W-1:0]  ra_data, rb_data, rc_data;
  logic          pc_redirect_valid;
  logic [W-1:0]  pc_redirect_target;

  wb_register_file #(.DATA_W(W), .NREG(16)) dut (
    .clk                (clk),
    .reset              (reset),
    .wb_control         (wb_control),
    .wb_rd              (wb_rd),
    .wb_alu_result      (wb_alu_result),
    .wb_mem_data        (wb_mem_data),
    .pc_plus8           (pc_plus8),
    .ra_addr            (ra_addr),
    .rb_addr            (rb_addr),
    .rc_addr            (rc_addr),
    .ra_data            (ra_data),
    .rb_data            (rb_data),
    .rc_data            (rc_data),
    .pc_redirect_valid  (pc_redirect_valid),
    .pc_redirect_target (pc_redirect_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rc;
    logic         v;
    logic [W-1:0] tgt;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   errors = 0;

  // Reference model state: the architectural registers and the redirect.
  logic [W-1:0] m_regs [15];
  logic         m_v;
  logic [W-1:0] m_tgt;

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic logic [W-1:0] model_wdata(input logic [3:0] c,
                                               input logic [W-1:0] alu,
                                               input logic [W-1:0] mem);
    if (!c[1]) return alu;
    if (c[2])  return {24'b0, mem[7:0]};
    return mem;
  endfunction

  function automatic logic [W-1:0] model_read(input logic [3:0] idx,
                                              input logic [3:0] c,
                                              input logic [3:0] rd,
                                              input logic [W-1:0] wd,
                                              input logic [W-1:0] pc8);
    if (idx == 4'd15) return pc8;
    if (BYPASS && c[0] && rd != 4'd15 && idx == rd) return wd;
    return m_regs[idx];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // One WB cycle: drive inputs, push expectations, advance the model.
  task automatic drive(input logic [3:0] c, input logic [3:0] rd,
                       input logic [W-1:0] alu, input logic [W-1:0] mem,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] cc, input logic rst);
    exp_t e;
    logic [W-1:0] wd;
    logic [W-1:0] pc8;
    @(negedge clk);
    pc8           = $urandom;
    wb_control    = c;
    wb_rd         = rd;
    wb_alu_result = alu;
    wb_mem_data   = mem;
    pc_plus8      = pc8;
    ra_addr       = a;
    rb_addr       = b;
    rc_addr       = cc;
    reset         = rst;
    wd   = model_wdata(c, alu, mem);
    e.ra = model_read(a, c, rd, wd, pc8);
    e.rb = model_read(b, c, rd, wd, pc8);
    e.rc = model_read(cc, c, rd, wd, pc8);
    e.v  = m_v;
    e.tgt = m_tgt;
    q.push_back(e);
    if (rst) begin
      for (int i = 0; i < 15; i++) m_regs[i] = '0;
      m_v   = 1'b0;
      m_tgt = '0;
    end else begin
      m_v = c[0] && (rd == 4'd15);
      if (m_v) m_tgt = wd & ~32'd3;
      if (c[0] && rd != 4'd15) m_regs[rd] = wd;
    end
  endtask

  // Monitor: compare every presented cycle mid-low-phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ra_data", ra_data, e.ra);
        check("rb_data", rb_data, e.rb);
        check("rc_data", rc_data, e.rc);
        check("pc_redirect_valid", W'(pc_redirect_valid), W'(e.v));
        if (e.v) check("pc_redirect_target", pc_redirect_target, e.tgt);
      end
    end
  end

  initial begin
    for (int i = 0; i < 15; i++) m_regs[i] = '0;
    m_v = 1'b0;
    m_tgt = '0;
    reset = 1'b1;
    wb_control = '0; wb_rd = '0; wb_alu_result = '0; wb_mem_data = '0;
    pc_plus8 = '0; ra_addr = '0; rb_addr = '0; rc_addr = '0;
    repeat (2) @(posedge clk);

    // Reset state on every stored index.
    for (int i = 0; i < 15; i++)
      drive(4'b0000, 4'd0, 32'h0, 32'h0, 4'(i), 4'(i), 4'(i), 1'b0);

    // ALU write, then a disabled write must not change R3.
    drive(4'b0001, 4'd3, 32'hDEADBEEF, 32'h0, 4'd0, 4'd1, 4'd2, 1'b0);
    drive(4'b0000, 4'd3, 32'h11111111, 32'h0, 4'd3, 4'd3, 4'd3, 1'b0);
    drive(4'b0000, 4'd0, 32'h0, 32'h0, 4'd3, 4'd0, 4'd15, 1'b0);

    // Byte load, then word load into R5.
    drive(4'b0111, 4'd5, 32'h0, 32'h123456A7, 4'd5, 4'd3, 4'd0, 1'b0);
    drive(4'b0011, 4'd5, 32'hFFFFFFFF, 32'h123456A7, 4'd5, 4'd5, 4'd5, 1'b0);
    drive(4'b1000, 4'd5, 32'h0, 32'h0, 4'd5, 4'd3, 4'd5, 1'b0);

    // Same-cycle write and read of R7.
    drive(4'b0001, 4'd7, 32'h00000055, 32'h0, 4'd7, 4'd7, 4'd6, 1'b0);
    drive(4'b0000, 4'd0, 32'h0, 32'h0, 4'd7, 4'd7, 4'd7, 1'b0);

    // R15 write: pulse next cycle, gone the cycle after.
    drive(4'b0001, 4'd15, 32'h00001003, 32'h0, 4'd15, 4'd15, 4'd3, 1'b0);
    drive(4'b0000, 4'd0, 32'h0, 32'h0, 4'd15, 4'd7, 4'd15, 1'b0);
    drive(4'b0000, 4'd0, 32'h0, 32'h0, 4'd15, 4'd5, 4'd3, 1'b0);

    // Back-to-back R15 writes with distinct targets.
    drive(4'b0001, 4'd15, 32'h00002007, 32'h0, 4'd1, 4'd2, 4'd3, 1'b0);
    drive(4'b0011, 4'd15, 32'h0, 32'hABCDEF02, 4'd1, 4'd2, 4'd3, 1'b0);
    drive(4'b0000, 4'd0, 32'h0, 32'h0, 4'd1, 4'd2, 4'd3, 1'b0);

    // R15 write with reset in the same cycle: no pulse.
    drive(4'b0001, 4'd15, 32'h00001003, 32'h0, 4'd7, 4'd3, 4'd5, 1'b1);
    drive(4'b0000, 4'd0, 32'h0, 32'h0, 4'd7, 4'd3, 4'd5, 1'b0);

    // Reset arriving during a redirect pulse clears it.
    drive(4'b0001, 4'd15, 32'h00004000, 32'h0, 4'd0, 4'd0, 4'd0, 1'b0);
    drive(4'b0000, 4'd0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0, 1'b1);
    drive(4'b0000, 4'd0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0, 1'b0);

    // Write R2 with reset in the same cycle: R2 stays 0.
    drive(4'b0001, 4'd2, 32'h000000AA, 32'h0, 4'd2, 4'd2, 4'd2, 1'b1);
    drive(4'b0000, 4'd0, 32'h0, 32'h0, 4'd2, 4'd2, 4'd2, 1'b0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++)
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            $urandom, $urandom,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), ($urandom_range(0, 31) == 0));

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    #5;
    if (q.size() != 0) begin
      tests++;
      errors++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
